// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types, op codes and widths for the reorder buffer slice.
// Tag = entry index + 1; tag 0 means "no dependency".
package reorder_buffer_pkg;

    localparam int ROB_SIZE   = 16;
    localparam int ROB_IDX_W  = 4;
    localparam int ROB_ID_W   = ROB_IDX_W + 1;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int OPE_WIDTH  = 6;

    typedef logic [ROB_ID_W-1:0] rob_id_t;

    localparam rob_id_t NON_DEPENDENT = '0;

    typedef enum logic [OPE_WIDTH-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_LB    = 6'd11,
        OP_LH    = 6'd12,
        OP_LW    = 6'd13,
        OP_LBU   = 6'd14,
        OP_LHU   = 6'd15,
        OP_SB    = 6'd16,
        OP_SH    = 6'd17,
        OP_SW    = 6'd18,
        OP_ADDI  = 6'd19,
        OP_SLTI  = 6'd20,
        OP_XORI  = 6'd21,
        OP_ORI   = 6'd22,
        OP_ANDI  = 6'd23,
        OP_ADD   = 6'd24,
        OP_SUB   = 6'd25,
        OP_AND   = 6'd26,
        OP_OR    = 6'd27,
        OP_XOR   = 6'd28
    } op_e;

    function automatic logic op_is_branch(logic [OPE_WIDTH-1:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

    function automatic logic op_is_store(logic [OPE_WIDTH-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Branches and stores never write the register file
    function automatic logic op_no_rd(logic [OPE_WIDTH-1:0] op);
        return op_is_branch(op) || op_is_store(op);
    endfunction

endpackage

// File: rtl/reorder_buffer_branch_check.sv
// Retire-time control-flow check: flags a wrong prediction or any JALR.
// Purely combinational; evaluated on the ROB head entry.
module rob_branch_check
    import reorder_buffer_pkg::*;
(
    input  logic [OPE_WIDTH-1:0] i_type,
    input  logic                 i_pred_jump,
    input  logic                 i_jump,
    output logic                 o_mispredict
);

    logic w_predicted;
    logic w_wrong;

    assign w_predicted = op_is_branch(i_type) || (i_type == OP_JAL);
    assign w_wrong     = i_jump != i_pred_jump;

    // JALR target is never predicted, so it always redirects fetch
    assign o_mispredict = (w_predicted && w_wrong) || (i_type == OP_JALR);

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: tag allocation, dual CDB capture, single retire.
// Optional perf counters when ROB_PERF_CNT_EN is defined.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  alloc_en,
    input  logic [OPE_WIDTH-1:0]  alloc_type,
    input  logic [4:0]            alloc_rd,
    input  logic [ADDR_WIDTH-1:0] alloc_pc,
    input  logic                  alloc_pred_jump,
    output rob_id_t               alloc_rob_id,
    output logic                  full_rob,
    input  rob_id_t               query_qj,
    input  rob_id_t               query_qk,
    output logic                  query_qj_ready,
    output logic                  query_qk_ready,
    output logic [DATA_WIDTH-1:0] query_qj_value,
    output logic [DATA_WIDTH-1:0] query_qk_value,
    input  logic                  enable_cdb_rs,
    input  rob_id_t               cdb_rs_rob_id,
    input  logic [DATA_WIDTH-1:0] cdb_rs_value,
    input  logic                  cdb_rs_jump,
    input  logic [ADDR_WIDTH-1:0] cdb_rs_pc_next,
    input  logic                  enable_cdb_lsb,
    input  rob_id_t               cdb_lsb_rob_id,
    input  logic [DATA_WIDTH-1:0] cdb_lsb_value,
    output logic                  commit_en,
    output rob_id_t               commit_rob_id,
    output logic [4:0]            commit_rd,
    output logic [DATA_WIDTH-1:0] commit_value,
    output logic                  commit_store,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] mispredict_pc
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_commit_cnt,
    output logic [31:0]           perf_mispredict_cnt
`endif
);

    logic [ROB_IDX_W-1:0]  r_head;
    logic [ROB_IDX_W-1:0]  r_tail;
    logic [ROB_IDX_W:0]    r_count;
    logic [ROB_SIZE-1:0]   r_busy;
    logic [ROB_SIZE-1:0]   r_ready;
    logic [OPE_WIDTH-1:0]  r_type    [ROB_SIZE];
    logic [4:0]            r_rd      [ROB_SIZE];
    logic                  r_pred    [ROB_SIZE];
    logic                  r_jump    [ROB_SIZE];
    logic [DATA_WIDTH-1:0] r_value   [ROB_SIZE];
    logic [ADDR_WIDTH-1:0] r_pc_next [ROB_SIZE];

    logic                  w_alloc;
    logic                  w_commit;
    logic                  w_mis;
    logic                  w_flush;
    logic [ROB_IDX_W-1:0]  w_rs_idx;
    logic [ROB_IDX_W-1:0]  w_lsb_idx;
    logic                  w_rs_hit;
    logic                  w_lsb_hit;
    logic [DATA_WIDTH:0]   w_qj;
    logic [DATA_WIDTH:0]   w_qk;

    assign full_rob     = r_count == (ROB_IDX_W+1)'(ROB_SIZE);
    assign alloc_rob_id = {1'b0, r_tail} + ROB_ID_W'(1);
    assign w_alloc      = alloc_en && !full_rob;
    assign w_commit     = r_busy[r_head] && r_ready[r_head];
    assign w_flush      = w_commit && w_mis;

    assign w_rs_idx  = cdb_rs_rob_id[ROB_IDX_W-1:0] - ROB_IDX_W'(1);
    assign w_lsb_idx = cdb_lsb_rob_id[ROB_IDX_W-1:0] - ROB_IDX_W'(1);
    assign w_rs_hit  = enable_cdb_rs && (cdb_rs_rob_id != NON_DEPENDENT)
                       && r_busy[w_rs_idx];
    assign w_lsb_hit = enable_cdb_lsb && (cdb_lsb_rob_id != NON_DEPENDENT)
                       && r_busy[w_lsb_idx];

    rob_branch_check u_branch_check (
        .i_type       (r_type[r_head]),
        .i_pred_jump  (r_pred[r_head]),
        .i_jump       (r_jump[r_head]),
        .o_mispredict (w_mis)
    );

    // {ready, value}; a same-cycle broadcast beats the stored entry
    function automatic logic [DATA_WIDTH:0] f_query(rob_id_t t);
        logic [ROB_IDX_W-1:0] idx;
        logic [DATA_WIDTH:0]  res;
        idx = t[ROB_IDX_W-1:0] - ROB_IDX_W'(1);
        res = {1'b0, r_value[idx]};
        if (t != NON_DEPENDENT) begin
            if (enable_cdb_rs && cdb_rs_rob_id == t)
                res = {1'b1, cdb_rs_value};
            else if (enable_cdb_lsb && cdb_lsb_rob_id == t)
                res = {1'b1, cdb_lsb_value};
            else
                res = {r_ready[idx], r_value[idx]};
        end
        return res;
    endfunction

    always_comb begin
        w_qj = f_query(query_qj);
        w_qk = f_query(query_qk);
    end

    assign query_qj_ready = w_qj[DATA_WIDTH];
    assign query_qj_value = w_qj[DATA_WIDTH-1:0];
    assign query_qk_ready = w_qk[DATA_WIDTH];
    assign query_qk_value = w_qk[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_busy        <= '0;
            r_ready       <= '0;
            commit_en     <= 1'b0;
            commit_rob_id <= '0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_store  <= 1'b0;
            mispredict    <= 1'b0;
            mispredict_pc <= '0;
        end else if (rdy) begin
            commit_en    <= w_commit;
            commit_store <= w_commit && op_is_store(r_type[r_head]);
            mispredict   <= w_flush;
            if (w_commit) begin
                commit_rob_id <= {1'b0, r_head} + ROB_ID_W'(1);
                commit_rd     <= op_no_rd(r_type[r_head]) ? 5'd0
                                                           : r_rd[r_head];
                commit_value  <= r_value[r_head];
            end
            if (w_flush) begin
                mispredict_pc <= r_pc_next[r_head];
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                r_busy        <= '0;
                r_ready       <= '0;
            end else begin
                if (w_alloc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + ROB_IDX_W'(1);
                end
                if (w_lsb_hit)
                    r_ready[w_lsb_idx] <= 1'b1;
                if (w_rs_hit)
                    r_ready[w_rs_idx] <= 1'b1;
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + ROB_IDX_W'(1);
                end
                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + (ROB_IDX_W+1)'(1);
                    2'b01:   r_count <= r_count - (ROB_IDX_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload needs no reset: busy/ready gate every use
    always_ff @(posedge clk) begin
        if (!rst && rdy && !w_flush) begin
            if (w_alloc) begin
                r_type[r_tail]    <= alloc_type;
                r_rd[r_tail]      <= alloc_rd;
                r_pred[r_tail]    <= alloc_pred_jump;
                r_jump[r_tail]    <= 1'b0;
                r_pc_next[r_tail] <= alloc_pc + 32'd4;
            end
            if (w_lsb_hit)
                r_value[w_lsb_idx] <= cdb_lsb_value;
            if (w_rs_hit) begin
                r_value[w_rs_idx]   <= cdb_rs_value;
                r_jump[w_rs_idx]    <= cdb_rs_jump;
                r_pc_next[w_rs_idx] <= cdb_rs_pc_next;
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commit_cnt     <= '0;
            perf_mispredict_cnt <= '0;
        end else if (rdy) begin
            if (w_commit)
                perf_commit_cnt <= perf_commit_cnt + 32'd1;
            if (w_flush)
                perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomised bench for reorder_buffer against a queue-based ROB model.
// Directed scenarios first, then a long random run.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        alloc_en;
    logic [5:0]  alloc_type;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc;
    logic        alloc_pred_jump;
    logic [4:0]  alloc_rob_id;
    logic        full_rob;
    logic [4:0]  query_qj, query_qk;
    logic        query_qj_ready, query_qk_ready;
    logic [31:0] query_qj_value, query_qk_value;
    logic        enable_cdb_rs;
    logic [4:0]  cdb_rs_rob_id;
    logic [31:0] cdb_rs_value;
    logic        cdb_rs_jump;
    logic [31:0] cdb_rs_pc_next;
    logic        enable_cdb_lsb;
    logic [4:0]  cdb_lsb_rob_id;
    logic [31:0] cdb_lsb_value;
    logic        commit_en;
    logic [4:0]  commit_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        commit_store;
    logic        mispredict;
    logic [31:0] mispredict_pc;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_cnt, perf_mispredict_cnt;
`endif

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_en(alloc_en), .alloc_type(alloc_type),
        .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
        .alloc_pred_jump(alloc_pred_jump),
        .alloc_rob_id(alloc_rob_id), .full_rob(full_rob),
        .query_qj(query_qj), .query_qk(query_qk),
        .query_qj_ready(query_qj_ready),
        .query_qk_ready(query_qk_ready),
        .query_qj_value(query_qj_value),
        .query_qk_value(query_qk_value),
        .enable_cdb_rs(enable_cdb_rs), .cdb_rs_rob_id(cdb_rs_rob_id),
        .cdb_rs_value(cdb_rs_value), .cdb_rs_jump(cdb_rs_jump),
        .cdb_rs_pc_next(cdb_rs_pc_next),
        .enable_cdb_lsb(enable_cdb_lsb),
        .cdb_lsb_rob_id(cdb_lsb_rob_id),
        .cdb_lsb_value(cdb_lsb_value),
        .commit_en(commit_en), .commit_rob_id(commit_rob_id),
        .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_store(commit_store),
        .mispredict(mispredict), .mispredict_pc(mispredict_pc)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_commit_cnt(perf_commit_cnt),
        .perf_mispredict_cnt(perf_mispredict_cnt)
`endif
    );

    typedef struct {
        logic [4:0]  tag;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        pred;
        bit          done;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pcn;
    } ent_t;

    ent_t        q[$];
    int          next_tag;
    int          checks = 0;
    int          errors = 0;
    logic        e_cen, e_store, e_mis;
    logic [4:0]  e_cid, e_crd;
    logic [31:0] e_cval, e_mpc;
    logic [31:0] m_cc, m_mc;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit is_cond(logic [5:0] op);
        return op == OP_BEQ || op == OP_BNE || op == OP_BLT ||
               op == OP_BGE || op == OP_BLTU || op == OP_BGEU;
    endfunction

    function automatic bit is_st(logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic bit is_mem(logic [5:0] op);
        return is_st(op) || op == OP_LB || op == OP_LH || op == OP_LW ||
               op == OP_LBU || op == OP_LHU;
    endfunction

    function automatic bit wrong_path(ent_t e);
        if (e.op == OP_JALR) return 1'b1;
        if (is_cond(e.op) || e.op == OP_JAL) return e.jump != e.pred;
        return 1'b0;
    endfunction

    task automatic idle();
        rdy = 1'b1; alloc_en = 1'b0; alloc_type = OP_NOP;
        alloc_rd = '0; alloc_pc = '0; alloc_pred_jump = 1'b0;
        query_qj = '0; query_qk = '0;
        enable_cdb_rs = 1'b0; cdb_rs_rob_id = '0; cdb_rs_value = '0;
        cdb_rs_jump = 1'b0; cdb_rs_pc_next = '0;
        enable_cdb_lsb = 1'b0; cdb_lsb_rob_id = '0; cdb_lsb_value = '0;
    endtask

    task automatic alloc(logic [5:0] op, logic [4:0] rd, logic [31:0] pc,
                         logic pj);
        alloc_en = 1'b1; alloc_type = op; alloc_rd = rd;
        alloc_pc = pc; alloc_pred_jump = pj;
    endtask

    task automatic rs(logic [4:0] t, logic [31:0] v, logic j,
                      logic [31:0] pn);
        enable_cdb_rs = 1'b1; cdb_rs_rob_id = t; cdb_rs_value = v;
        cdb_rs_jump = j; cdb_rs_pc_next = pn;
    endtask

    task automatic check_query(string nm, logic [4:0] t, logic r,
                               logic [31:0] v);
        bit er;
        logic [31:0] ev;
        er = 1'b0; ev = '0;
        if (t != 0) begin
            if (enable_cdb_rs && cdb_rs_rob_id == t) begin
                er = 1'b1; ev = cdb_rs_value;
            end else if (enable_cdb_lsb && cdb_lsb_rob_id == t) begin
                er = 1'b1; ev = cdb_lsb_value;
            end else begin
                foreach (q[i])
                    if (q[i].tag == t && q[i].done) begin
                        er = 1'b1; ev = q[i].val;
                    end
            end
        end
        check({nm, "_ready"}, 32'(r), 32'(er));
        if (er) check({nm, "_value"}, v, ev);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete(); next_tag = 1;
        e_cen = 0; e_store = 0; e_mis = 0; e_cid = 0; e_crd = 0;
        e_cval = 0; e_mpc = 0; m_cc = 0; m_mc = 0;
        check("rst_commit_en", 32'(commit_en), 0);
        check("rst_mispredict", 32'(mispredict), 0);
        check("rst_commit_store", 32'(commit_store), 0);
        check("rst_commit_id", 32'(commit_rob_id), 0);
        check("rst_commit_val", commit_value, 0);
        check("rst_mis_pc", mispredict_pc, 0);
        check("rst_alloc_id", 32'(alloc_rob_id), 1);
        check("rst_full", 32'(full_rob), 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Inputs are already driven; check comb outputs, advance model, check regs
    task automatic step();
        bit commit, can_alloc;
        ent_t e;
        #1;
        check("alloc_id", 32'(alloc_rob_id), 32'(next_tag));
        check("full_rob", 32'(full_rob), 32'(q.size() == 16));
        check_query("qj", query_qj, query_qj_ready, query_qj_value);
        check_query("qk", query_qk, query_qk_ready, query_qk_value);
        can_alloc = alloc_en && q.size() < 16;
        if (rdy) begin
            commit = q.size() > 0 && q[0].done;
            e_cen = commit; e_mis = 1'b0; e_store = 1'b0;
            if (commit) begin
                e_cid = q[0].tag;
                e_crd = (is_cond(q[0].op) || is_st(q[0].op)) ? 5'd0 : q[0].rd;
                e_cval = q[0].val;
                e_store = is_st(q[0].op);
                e_mis = wrong_path(q[0]);
                if (e_mis) e_mpc = q[0].pcn;
            end
            m_cc += 32'(e_cen);
            m_mc += 32'(e_mis);
            if (e_mis) begin
                q.delete(); next_tag = 1;
            end else begin
                if (enable_cdb_lsb && cdb_lsb_rob_id != 0)
                    foreach (q[i]) if (q[i].tag == cdb_lsb_rob_id) begin
                        q[i].done = 1'b1; q[i].val = cdb_lsb_value;
                    end
                if (enable_cdb_rs && cdb_rs_rob_id != 0)
                    foreach (q[i]) if (q[i].tag == cdb_rs_rob_id) begin
                        q[i].done = 1'b1; q[i].val = cdb_rs_value;
                        q[i].jump = cdb_rs_jump; q[i].pcn = cdb_rs_pc_next;
                    end
                if (commit) void'(q.pop_front());
                if (can_alloc) begin
                    e.tag = 5'(next_tag); e.op = alloc_type; e.rd = alloc_rd;
                    e.pred = alloc_pred_jump; e.done = 1'b0; e.val = '0;
                    e.jump = 1'b0; e.pcn = alloc_pc + 32'd4;
                    q.push_back(e);
                    next_tag = (next_tag == 16) ? 1 : next_tag + 1;
                end
            end
        end
        @(posedge clk); #1;
        check("commit_en", 32'(commit_en), 32'(e_cen));
        check("mispredict", 32'(mispredict), 32'(e_mis));
        check("commit_store", 32'(commit_store), 32'(e_store));
        if (e_cen) begin
            check("commit_id", 32'(commit_rob_id), 32'(e_cid));
            check("commit_rd", 32'(commit_rd), 32'(e_crd));
            check("commit_value", commit_value, e_cval);
        end
        if (e_mis) check("mispredict_pc", mispredict_pc, e_mpc);
`ifdef ROB_PERF_CNT_EN
        check("perf_commit", perf_commit_cnt, m_cc);
        check("perf_mis", perf_mispredict_cnt, m_mc);
`endif
        @(negedge clk);
    endtask

    logic [5:0] ops [10];

    task automatic rand_inputs();
        int c[$];
        int k;
        logic [5:0] op;
        idle();
        rdy = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 2) != 0) begin
            k = int'($urandom_range(0, 9));
            if (k == 9 && $urandom_range(0, 3) != 0) k = 0;
            op = ops[k];
            alloc(op, 5'($urandom_range(0, 31)), $urandom,
                  (op == OP_JAL) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        foreach (q[i]) if (!q[i].done) c.push_back(i);
        if (c.size() > 0 && $urandom_range(0, 3) != 0) begin
            k = c[$urandom_range(0, c.size() - 1)];
            if (is_mem(q[k].op) && $urandom_range(0, 1) == 1) begin
                enable_cdb_lsb = 1'b1; cdb_lsb_rob_id = q[k].tag;
                cdb_lsb_value = $urandom;
                if ($urandom_range(0, 3) == 0)
                    rs(q[k].tag, $urandom, 1'b0, $urandom);
            end else begin
                rs(q[k].tag, $urandom,
                   (is_cond(q[k].op) || q[k].op == OP_JAL) ?
                   (($urandom_range(0, 4) == 0) ? !q[k].pred : q[k].pred) :
                   1'($urandom_range(0, 1)), $urandom);
            end
        end else if ($urandom_range(0, 3) == 0) begin
            rs(5'($urandom_range(0, 16)), $urandom, 1'b0, $urandom);
        end
        query_qj = (enable_cdb_rs && $urandom_range(0, 2) == 0) ?
                   cdb_rs_rob_id : 5'($urandom_range(0, 16));
        query_qk = (enable_cdb_lsb && $urandom_range(0, 2) == 0) ?
                   cdb_lsb_rob_id : 5'($urandom_range(0, 16));
    endtask

    initial begin
        ops = '{OP_ADDI, OP_ADD, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                OP_JAL, OP_LUI, OP_LB, OP_JALR};
        idle();
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // single ALU op retires the cycle after its broadcast
        alloc(OP_ADDI, 5'd5, 32'h10, 1'b0); step(); idle();
        rs(5'd1, 32'd7, 1'b0, 32'h14); step(); idle();
        step();
        check("t1_commit_rd", 32'(commit_rd), 5);
        check("t1_commit_val", commit_value, 7);

        // out-of-order writeback, in-order retire
        do_reset();
        alloc(OP_ADD, 5'd1, 32'h0, 1'b0); step();
        alloc(OP_ADD, 5'd2, 32'h4, 1'b0); step(); idle();
        rs(5'd2, 32'h22, 1'b0, 32'h8); step(); idle();
        rs(5'd1, 32'h11, 1'b0, 32'h4); step(); idle();
        step(); step(); step();

        // fill, refuse, drain one, wrap tag
        do_reset();
        for (int i = 0; i < 17; i++) begin
            alloc(OP_SW, 5'(i), 32'(i * 4), 1'b0); step();
        end
        idle();
        check("t3_full", 32'(full_rob), 1);
        enable_cdb_lsb = 1'b1; cdb_lsb_rob_id = 5'd1; step(); idle();
        step();
        alloc(OP_ADDI, 5'd3, 32'h80, 1'b0); step(); idle();
        step();

        // wrong branch flushes everything
        do_reset();
        alloc(OP_BEQ, 5'd0, 32'h40, 1'b0); step();
        alloc(OP_ADDI, 5'd4, 32'h44, 1'b0); step(); idle();
        rs(5'd1, 32'd0, 1'b1, 32'h100); step(); idle();
        alloc(OP_ADDI, 5'd6, 32'h48, 1'b0); rs(5'd2, 32'd9, 1'b0, 32'h48);
        step(); idle();
        check("t4_mis_pc", mispredict_pc, 32'h100);
        check("t4_next_id", 32'(alloc_rob_id), 1);
        step();

        // forwarding from same-cycle broadcast
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc(OP_ADD, 5'(i + 1), 32'(i * 4), 1'b0); step();
        end
        idle();
        rs(5'd3, 32'h55, 1'b0, 32'hc); query_qj = 5'd3; query_qk = 5'd2;
        #1;
        check("t5_qj_ready", 32'(query_qj_ready), 1);
        check("t5_qj_value", query_qj_value, 32'h55);
        step(); idle();

        // stall with a ready head, then release; reset mid-run
        do_reset();
        alloc(OP_LW, 5'd9, 32'h20, 1'b0); step(); idle();
        enable_cdb_lsb = 1'b1; cdb_lsb_rob_id = 5'd1;
        cdb_lsb_value = 32'hbeef; step(); idle();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) step();
        idle();
        step(); step();
        alloc(OP_ADDI, 5'd1, 32'h0, 1'b0); step(); step();
        do_reset();

        for (int n = 0; n < 4000; n++) begin
            rand_inputs();
            step();
        end
        idle();
        for (int n = 0; n < 4; n++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
